// File: rtl/stop_comma_align_if.sv
// Serial-in / byte-out link bundle for the comma-aligning deserialiser.
// slave is the deserialiser side, master is the line driver / byte consumer.
interface stop_comma_align_if;
  logic       in;
  logic [7:0] out;
  logic       out_valid;
  logic       byte_strobe;
  logic       active;

  modport master (output in, input out, out_valid, byte_strobe, active);
  modport slave  (input in, output out, out_valid, byte_strobe, active);
endinterface

// File: rtl/stop_comma_align.sv
// Serial-to-parallel converter that finds byte boundaries from the comma symbol,
// declares the link active after a run of aligned commas and drops it on repeated slips.
module stop_comma_align #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int unsigned SYNC_COMMAS = 4,
  parameter int unsigned LOSS_COMMAS = 4
) (
  input logic               clk32f,
  input logic               reset,
  stop_comma_align_if.slave link
);

  localparam int unsigned CW = $clog2(SYNC_COMMAS + 1);
  localparam int unsigned MW = $clog2(LOSS_COMMAS + 1);

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StCount  = 2'd1,
    StActive = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [6:0]      r_sr;
  logic [2:0]      r_bit_cnt;
  logic [2:0]      w_bit_cnt_d;
  logic [CW-1:0]   r_comma_cnt;
  logic [CW-1:0]   w_comma_cnt_d;
  logic [MW-1:0]   r_miss_cnt;
  logic [MW-1:0]   w_miss_cnt_d;
  logic [7:0]      r_out;
  logic [7:0]      w_out_d;
  logic            r_out_valid;
  logic            w_out_valid_d;
  logic            r_strobe;
  logic            w_strobe_d;

  logic [7:0]      w_nxt;
  logic            w_is_comma;
  logic            w_boundary;
  logic [CW-1:0]   w_comma_inc;
  logic [MW-1:0]   w_miss_inc;

  assign w_nxt       = {r_sr, link.in};
  assign w_is_comma  = (w_nxt == COMMA);
  assign w_boundary  = (r_bit_cnt == 3'd7);
  assign w_comma_inc = r_comma_cnt + CW'(1);
  assign w_miss_inc  = (r_miss_cnt == MW'(LOSS_COMMAS)) ? r_miss_cnt : r_miss_cnt + MW'(1);

  always_comb begin
    w_state_d     = r_state;
    w_bit_cnt_d   = r_bit_cnt + 3'd1;
    w_comma_cnt_d = r_comma_cnt;
    w_miss_cnt_d  = r_miss_cnt;
    w_out_d       = r_out;
    w_out_valid_d = r_out_valid;
    w_strobe_d    = 1'b0;
    case (r_state)
      StSearch: begin
        // A comma hit defines the phase: the next bit is the MSB of the next byte.
        if (w_is_comma) begin
          w_bit_cnt_d   = 3'd0;
          w_comma_cnt_d = CW'(1);
          w_miss_cnt_d  = '0;
          w_state_d     = (SYNC_COMMAS == 1) ? StActive : StCount;
        end
      end
      StCount: begin
        if (w_boundary) begin
          if (w_is_comma) begin
            w_comma_cnt_d = w_comma_inc;
            if (w_comma_inc == CW'(SYNC_COMMAS)) begin
              w_state_d = StActive;
            end
          end else begin
            w_state_d     = StSearch;
            w_comma_cnt_d = '0;
          end
        end
      end
      StActive: begin
        // A comma off the boundary means the phase slipped; loss beats delivery.
        if (w_is_comma && !w_boundary) begin
          if (w_miss_inc == MW'(LOSS_COMMAS)) begin
            w_state_d     = StSearch;
            w_out_valid_d = 1'b0;
            w_miss_cnt_d  = '0;
            w_comma_cnt_d = '0;
          end else begin
            w_miss_cnt_d  = w_miss_inc;
          end
        end else if (w_boundary) begin
          w_out_d       = w_nxt;
          w_out_valid_d = !w_is_comma;
          w_strobe_d    = 1'b1;
          if (w_is_comma) begin
            w_miss_cnt_d = '0;
          end
        end
      end
      default: begin
        w_state_d     = StSearch;
        w_comma_cnt_d = '0;
        w_miss_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      r_state     <= StSearch;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_comma_cnt <= '0;
      r_miss_cnt  <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_strobe    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_sr        <= w_nxt[6:0];
      r_bit_cnt   <= w_bit_cnt_d;
      r_comma_cnt <= w_comma_cnt_d;
      r_miss_cnt  <= w_miss_cnt_d;
      r_out       <= w_out_d;
      r_out_valid <= w_out_valid_d;
      r_strobe    <= w_strobe_d;
    end
  end

  assign link.out         = r_out;
  assign link.out_valid   = r_out_valid;
  assign link.byte_strobe = r_strobe;
  assign link.active      = (r_state == StActive);

endmodule
